// File: rtl/seg7_scan_reader_pkg.sv
// Shared constants for the 7-segment scan reader: segment patterns for the
// digits 0-9 and blank, the blank BCD code, the decimal-point mask and FSM
// state encodings. The forward BCD-to-segment path uses the same patterns.
package seg7_scan_reader_pkg;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high
    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // BCD code reported for a blanked (all segments off) digit
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Position of the decimal point on the 8-bit segment bus
    localparam logic [7:0] SEG_DP_MASK = 8'h80;

    // Frame assembly FSM states
    localparam logic [1:0] ST_HUNT = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/seg7_scan_reader_to_bcd.sv
// Combinational inverse of the BCD-to-segment decoder. Recognised digit
// patterns map to 0-9, an all-off pattern maps to the blank code, and any
// other pattern is flagged as illegal.
module seg7_scan_reader_to_bcd
    import seg7_scan_reader_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] bcd,
    output logic       illegal
);

    // Pattern lookup; anything not in the table is illegal
    always_comb begin
        bcd     = 4'h0;
        illegal = 1'b0;
        case (pattern)
            SEG_0:     bcd = 4'd0;
            SEG_1:     bcd = 4'd1;
            SEG_2:     bcd = 4'd2;
            SEG_3:     bcd = 4'd3;
            SEG_4:     bcd = 4'd4;
            SEG_5:     bcd = 4'd5;
            SEG_6:     bcd = 4'd6;
            SEG_7:     bcd = 4'd7;
            SEG_8:     bcd = 4'd8;
            SEG_9:     bcd = 4'd9;
            SEG_BLANK: bcd = BCD_BLANK;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Multiplexed 7-segment bus reader. Registers the segment and digit-select
// lines, waits for STABLE_CYCLES identical samples, decodes each stable digit
// once and assembles complete frames in scan order. A frame is published only
// when every digit arrived in order with a legal pattern.
// Build option: define SEG7_SCAN_READER_DP_EN to capture the decimal points;
// otherwise the dp line is ignored and o_dp stays 0.
module seg7_scan_reader
    import seg7_scan_reader_pkg::*;
#(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [7:0]              i_seg,
    input  logic [NUM_DIGITS-1:0]   i_dig_sel,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic [NUM_DIGITS-1:0]   o_dp,
    output logic                    o_frame_valid,
    output logic                    o_seq_err
);

    localparam int CNT_W = $clog2(STABLE_CYCLES);
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    logic [7:0]                   seg_in;
    logic [7:0]                   seg_q;
    logic [NUM_DIGITS-1:0]        sel_q;
    logic [CNT_W-1:0]             cnt;
    logic                         captured;
    logic                         sel_one_hot;
    logic                         capture;
    logic [IDX_W-1:0]             cap_idx;
    logic [3:0]                   dec_bcd;
    logic                         dec_ill;
    logic [1:0]                   state;
    logic [IDX_W-1:0]             idx;
    logic [NUM_DIGITS-1:0][3:0]   bcd_sh;
    logic [NUM_DIGITS-1:0]        dp_sh;
    logic [NUM_DIGITS-1:0]        ill_sh;

    // With dp disabled the dp line is masked off before the input register so
    // it can neither disturb stability nor reach the shadow registers.
`ifdef SEG7_SCAN_READER_DP_EN
    assign seg_in = i_seg;
`else
    assign seg_in = i_seg & ~SEG_DP_MASK;
`endif

    assign sel_one_hot = (sel_q != '0) && ((sel_q & (sel_q - NUM_DIGITS'(1))) == '0);
    assign capture     = (cnt == CNT_MAX) && sel_one_hot && !captured;

    // Binary index of the (one-hot) selected digit
    always_comb begin
        cap_idx = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel_q[k]) begin
                cap_idx = IDX_W'(k);
            end
        end
    end

    seg7_scan_reader_to_bcd u_to_bcd (
        .pattern (seg_q[6:0]),
        .bcd     (dec_bcd),
        .illegal (dec_ill)
    );

    // Input register, stability counter and one-capture-per-stable-period flag
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            seg_q    <= '0;
            sel_q    <= '0;
            cnt      <= '0;
            captured <= 1'b0;
        end else begin
            seg_q <= seg_in;
            sel_q <= i_dig_sel;
            if ({seg_in, i_dig_sel} != {seg_q, sel_q}) begin
                cnt      <= '0;
                captured <= 1'b0;
            end else begin
                if (cnt != CNT_MAX) begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (capture) begin
                    captured <= 1'b1;
                end
            end
        end
    end

    // Frame assembly FSM with shadow registers and published outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state         <= ST_HUNT;
            idx           <= '0;
            bcd_sh        <= '0;
            dp_sh         <= '0;
            ill_sh        <= '0;
            o_bcd         <= '0;
            o_dp          <= '0;
            o_frame_valid <= 1'b0;
            o_seq_err     <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            o_seq_err     <= 1'b0;
            case (state)
                ST_HUNT: begin
                    if (capture && cap_idx == '0) begin
                        bcd_sh[0] <= dec_bcd;
                        dp_sh[0]  <= seg_q[7];
                        ill_sh    <= NUM_DIGITS'(dec_ill);
                        idx       <= IDX_W'(1);
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (capture) begin
                        if (cap_idx == idx) begin
                            bcd_sh[cap_idx] <= dec_bcd;
                            dp_sh[cap_idx]  <= seg_q[7];
                            ill_sh[cap_idx] <= dec_ill;
                            if (idx == IDX_LAST) begin
                                state <= ST_DONE;
                            end else begin
                                idx <= idx + IDX_W'(1);
                            end
                        end else if (cap_idx == '0) begin
                            bcd_sh[0] <= dec_bcd;
                            dp_sh[0]  <= seg_q[7];
                            ill_sh    <= NUM_DIGITS'(dec_ill);
                            idx       <= IDX_W'(1);
                            o_seq_err <= 1'b1;
                        end else if (cap_idx == idx - IDX_W'(1)) begin
                            bcd_sh[cap_idx] <= dec_bcd;
                            dp_sh[cap_idx]  <= seg_q[7];
                            ill_sh[cap_idx] <= dec_ill;
                        end else begin
                            o_seq_err <= 1'b1;
                            state     <= ST_HUNT;
                        end
                    end
                end
                ST_DONE: begin
                    if (ill_sh != '0) begin
                        o_seq_err <= 1'b1;
                    end else begin
                        o_bcd         <= bcd_sh;
                        o_dp          <= dp_sh;
                        o_frame_valid <= 1'b1;
                    end
                    state <= ST_HUNT;
                end
                default: begin
                    state <= ST_HUNT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Scoreboard bench for seg7_scan_reader. Directed frames push their expected
// outcome (published frame or sequence error) into a queue; a monitor pops
// and compares on every o_frame_valid / o_seq_err pulse.
module tb_seg7_scan_reader;

    localparam int ND = 6;
`ifdef SEG7_SCAN_READER_DP_EN
    localparam bit DP_EN = 1'b1;
`else
    localparam bit DP_EN = 1'b0;
`endif

    typedef struct packed {
        logic        is_err;
        logic [23:0] bcd;
        logic [5:0]  dp;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [7:0]     seg = '0;
    logic [ND-1:0]  sel = '0;
    logic [4*ND-1:0] bcd_out;
    logic [ND-1:0]  dp_out;
    logic           frame_valid;
    logic           seq_err;

    exp_t           sb[$];
    exp_t           mon_e;
    int             compared = 0;
    int             mismatched = 0;

    seg7_scan_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(4)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_seg         (seg),
        .i_dig_sel     (sel),
        .o_bcd         (bcd_out),
        .o_dp          (dp_out),
        .o_frame_valid (frame_valid),
        .o_seq_err     (seq_err)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: seg_of = 7'h3F;
            4'd1: seg_of = 7'h06;
            4'd2: seg_of = 7'h5B;
            4'd3: seg_of = 7'h4F;
            4'd4: seg_of = 7'h66;
            4'd5: seg_of = 7'h6D;
            4'd6: seg_of = 7'h7D;
            4'd7: seg_of = 7'h07;
            4'd8: seg_of = 7'h7F;
            4'd9: seg_of = 7'h6F;
            default: seg_of = 7'h00;
        endcase
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Inputs change just after a falling edge and hold for the given cycles
    task automatic apply_stimulus(input logic [7:0] s, input logic [ND-1:0] d, input int cycles);
        seg = s;
        sel = d;
        repeat (cycles) @(negedge clk);
    endtask

    // One digit shown for 8 cycles then 2 cycles of blanking
    task automatic send_digit(input int k, input logic [7:0] s);
        apply_stimulus(s, ND'(1) << k, 8);
        apply_stimulus(8'h00, '0, 2);
    endtask

    // Full frame; digit gdig (if in range) carries a 1-cycle glitch value gseg at position gpos
    task automatic send_frame(input logic [23:0] b, input logic [5:0] dp,
                              input int gdig, input logic [7:0] gseg, input int gpos);
        logic [7:0] s;
        for (int k = 0; k < ND; k++) begin
            s = {dp[k], seg_of(b[4*k +: 4])};
            if (k == gdig) begin
                apply_stimulus(s, ND'(1) << k, gpos);
                apply_stimulus(gseg, ND'(1) << k, 1);
                apply_stimulus(s, ND'(1) << k, 7 - gpos);
                apply_stimulus(8'h00, '0, 2);
            end else begin
                send_digit(k, s);
            end
        end
    endtask

    task automatic expect_frame(input logic [23:0] b, input logic [5:0] dp);
        exp_t e;
        e.is_err = 1'b0;
        e.bcd    = b;
        e.dp     = DP_EN ? dp : 6'b0;
        sb.push_back(e);
    endtask

    task automatic expect_err(input logic [23:0] held_bcd, input logic [5:0] held_dp);
        exp_t e;
        e.is_err = 1'b1;
        e.bcd    = held_bcd;
        e.dp     = DP_EN ? held_dp : 6'b0;
        sb.push_back(e);
    endtask

    // Monitor: every output pulse must match the oldest expected event
    always @(negedge clk) begin
        if (frame_valid || seq_err) begin
            if (frame_valid && seq_err) begin
                check_output("pulse_exclusive", 32'(frame_valid & seq_err), 32'd0);
            end
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpected_pulse: got valid=%0b err=%0b, expected none (t=%0t)",
                         frame_valid, seq_err, $time);
            end else begin
                mon_e = sb.pop_front();
                check_output("event_kind_err", 32'(seq_err), 32'(mon_e.is_err));
                check_output("event_bcd", 32'(bcd_out), 32'(mon_e.bcd));
                check_output("event_dp", 32'(dp_out), 32'(mon_e.dp));
            end
        end
    end

    initial begin
        logic [7:0] s;
        $display("[TB] start, DP_EN=%0b", DP_EN);

        // Reset state
        rst_n = 1'b0;
        @(negedge clk);
        apply_stimulus(8'h00, '0, 3);
        check_output("reset_bcd", 32'(bcd_out), 32'd0);
        check_output("reset_dp", 32'(dp_out), 32'd0);
        check_output("reset_valid", 32'(frame_valid), 32'd0);
        check_output("reset_err", 32'(seq_err), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(8'h00, '0, 3);

        // 1: clean frame 1,2,3,4,5,9
        expect_frame(24'h954321, 6'b0);
        send_frame(24'h954321, 6'b0, -1, 8'h00, 0);

        // 2: one-cycle 7F glitch inside digit 2 is filtered
        expect_frame(24'h954321, 6'b0);
        send_frame(24'h954321, 6'b0, 2, 8'h7F, 2);

        // 3: illegal 0x49 on digit 3 -> error at DONE, outputs hold
        expect_err(24'h954321, 6'b0);
        for (int k = 0; k < ND; k++) begin
            s = (k == 3) ? 8'h49 : {1'b0, seg_of(4'(k + 1))};
            send_digit(k, s);
        end

        // 4: select order 0,1,3 -> error at digit 3, then a clean frame
        expect_err(24'h954321, 6'b0);
        send_digit(0, {1'b0, seg_of(4'd7)});
        send_digit(1, {1'b0, seg_of(4'd8)});
        send_digit(3, {1'b0, seg_of(4'd2)});
        expect_frame(24'h543210, 6'b0);
        send_frame(24'h543210, 6'b0, -1, 8'h00, 0);

        // 5: reset after digit 4 captured discards the frame
        for (int k = 0; k < 5; k++) begin
            send_digit(k, {1'b0, seg_of(4'(k + 3))});
        end
        rst_n = 1'b0;
        apply_stimulus(8'h00, '0, 2);
        check_output("midreset_bcd", 32'(bcd_out), 32'd0);
        check_output("midreset_dp", 32'(dp_out), 32'd0);
        rst_n = 1'b1;
        apply_stimulus(8'h00, '0, 2);
        expect_frame(24'h876543, 6'b0);
        send_frame(24'h876543, 6'b0, -1, 8'h00, 0);

        // 6: decimal points on digits 1 and 3
        expect_frame(24'h987654, 6'b001010);
        send_frame(24'h987654, 6'b001010, -1, 8'h00, 0);

        // 6b: dp toggles for one cycle after digit 2 capture, blank digit 5 reads F
        expect_frame(24'hF12345, 6'b0);
        send_frame(24'hF12345, 6'b0, 2, {1'b1, seg_of(4'd3)}, 5);

        // Bounded drain of outstanding expectations
        for (int i = 0; i < 200 && sb.size() != 0; i++) begin
            @(negedge clk);
        end
        check_output("scoreboard_drained", 32'(sb.size()), 32'd0);
        apply_stimulus(8'h00, '0, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
